// File: rtl/gf16_mult_arbiter_pkg.sv
// Shared constants and operand helpers for the GF(16) multiplier arbiter.
// Four requesters share one two-stage multiplier pipeline.
package gf16_mult_arbiter_pkg;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;
    localparam int NIB_W = 4;
    localparam int OPS_W = N_REQ * NIB_W;

    function automatic logic [NIB_W-1:0] nib_slice(
        input logic [OPS_W-1:0] v,
        input logic [ID_W-1:0]  i
    );
        return v[i*NIB_W +: NIB_W];
    endfunction

endpackage

// File: rtl/gf16_mult_arbiter_mult.sv
// Combinational GF(16) multiplier with optional constant addition.
// Operand bits map to x0..x3 = a, x4..x7 = b.
module Mult_GF16
    import gf16_mult_arbiter_pkg::*;
#(
    parameter int __ADD_CONSTANT = 0
) (
    input  logic [NIB_W-1:0] i_a,
    input  logic [NIB_W-1:0] i_b,
    input  logic [NIB_W-1:0] i_c,
    output logic [NIB_W-1:0] o_y
);

    logic [7:0]       w_x;
    logic [NIB_W-1:0] w_p;

    assign w_x = {i_b, i_a};

    assign w_p[0] = (w_x[0] & w_x[4]) ^ (w_x[1] & w_x[4]) ^ (w_x[2] & w_x[4])
                  ^ (w_x[0] & w_x[5]) ^ (w_x[3] & w_x[5]) ^ (w_x[0] & w_x[6])
                  ^ (w_x[2] & w_x[6]) ^ (w_x[1] & w_x[7]) ^ (w_x[3] & w_x[7]);

    assign w_p[1] = (w_x[0] & w_x[4]) ^ (w_x[3] & w_x[4]) ^ (w_x[1] & w_x[5])
                  ^ (w_x[2] & w_x[5]) ^ (w_x[3] & w_x[5]) ^ (w_x[1] & w_x[6])
                  ^ (w_x[3] & w_x[6]) ^ (w_x[0] & w_x[7]) ^ (w_x[1] & w_x[7])
                  ^ (w_x[2] & w_x[7]) ^ (w_x[3] & w_x[7]);

    assign w_p[2] = (w_x[0] & w_x[4]) ^ (w_x[2] & w_x[4]) ^ (w_x[1] & w_x[5])
                  ^ (w_x[3] & w_x[5]) ^ (w_x[0] & w_x[6]) ^ (w_x[2] & w_x[6])
                  ^ (w_x[3] & w_x[6]) ^ (w_x[1] & w_x[7]) ^ (w_x[2] & w_x[7]);

    assign w_p[3] = (w_x[1] & w_x[4]) ^ (w_x[3] & w_x[4]) ^ (w_x[0] & w_x[5])
                  ^ (w_x[1] & w_x[5]) ^ (w_x[2] & w_x[5]) ^ (w_x[3] & w_x[5])
                  ^ (w_x[1] & w_x[6]) ^ (w_x[2] & w_x[6]) ^ (w_x[0] & w_x[7])
                  ^ (w_x[1] & w_x[7]) ^ (w_x[3] & w_x[7]);

    assign o_y = w_p ^ ((__ADD_CONSTANT != 0) ? i_c : '0);

endmodule

// File: rtl/gf16_mult_arbiter.sv
// Round-robin arbiter feeding one shared GF(16) multiplier through
// an operand stage (S1) and a result stage (S2).
module gf16_mult_arbiter
    import gf16_mult_arbiter_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int ADD_CONSTANT = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*NIB_W-1:0]   req_a,
    input  logic [N_REQ*NIB_W-1:0]   req_b,
    input  logic [N_REQ*NIB_W-1:0]   req_c,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [NIB_W-1:0]         rsp_y,
    output logic                     busy
);

    logic             r_s1_valid;
    logic [NIB_W-1:0] r_s1_a;
    logic [NIB_W-1:0] r_s1_b;
    logic [NIB_W-1:0] r_s1_c;
    logic [ID_W-1:0]  r_s1_id;
    logic             r_s2_valid;
    logic [NIB_W-1:0] r_s2_y;
    logic [ID_W-1:0]  r_s2_id;
    logic [ID_W-1:0]  r_ptr;

    logic             w_s2_adv;
    logic             w_s1_acc;
    logic             w_any;
    logic [ID_W-1:0]  w_win;
    logic [NIB_W-1:0] w_prod;

    // Scan farthest-first so the requester nearest the pointer wins.
    always_comb begin
        w_any = 1'b0;
        w_win = r_ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid[r_ptr + ID_W'(k)]) begin
                w_any = 1'b1;
                w_win = r_ptr + ID_W'(k);
            end
        end
    end

    assign w_s2_adv  = !r_s2_valid || rsp_ready;
    assign w_s1_acc  = rst_n && (!r_s1_valid || w_s2_adv);
    assign req_ready = (w_s1_acc && w_any) ? (N_REQ'(1) << w_win) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_c     <= '0;
            r_s1_id    <= '0;
            r_ptr      <= '0;
        end else if (w_s1_acc) begin
            r_s1_valid <= w_any;
            if (w_any) begin
                r_s1_a  <= nib_slice(req_a, w_win);
                r_s1_b  <= nib_slice(req_b, w_win);
                r_s1_c  <= nib_slice(req_c, w_win);
                r_s1_id <= w_win;
                r_ptr   <= w_win + 1'b1;
            end
        end
    end

    Mult_GF16 #(
        .__ADD_CONSTANT(ADD_CONSTANT)
    ) u_mult (
        .i_a(r_s1_a),
        .i_b(r_s1_b),
        .i_c(r_s1_c),
        .o_y(w_prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_y     <= '0;
            r_s2_id    <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            r_s2_y     <= w_prod;
            r_s2_id    <= r_s1_id;
        end
    end

    assign rsp_valid = r_s2_valid;
    assign rsp_y     = r_s2_y;
    assign rsp_id    = r_s2_id;
    assign busy      = r_s1_valid || r_s2_valid;

endmodule

// File: tb/tb_gf16_mult_arbiter.sv
// Self-checking bench: two DUTs (ADD_CONSTANT 0 and 1) on shared stimulus,
// compared against a queue-based transaction model.
module tb_gf16_mult_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [15:0] req_a = '0;
    logic [15:0] req_b = '0;
    logic [15:0] req_c = '0;
    logic        rsp_ready = 1'b0;

    logic [3:0] rdy0, rdy1;
    logic       v0, v1, busy0, busy1;
    logic [1:0] id0, id1;
    logic [3:0] y0, y1;

    always #5 clk = ~clk;

    gf16_mult_arbiter #(.N_REQ(4), .ADD_CONSTANT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
        .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .req_ready(rdy0), .rsp_valid(v0), .rsp_ready(rsp_ready),
        .rsp_id(id0), .rsp_y(y0), .busy(busy0)
    );

    gf16_mult_arbiter #(.N_REQ(4), .ADD_CONSTANT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
        .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .req_ready(rdy1), .rsp_valid(v1), .rsp_ready(rsp_ready),
        .rsp_id(id1), .rsp_y(y1), .busy(busy1)
    );

    int errors = 0;
    int checks = 0;

    // Product terms per output bit: tens digit = a-bit index, units = x index (4..7).
    localparam int TERMS [4][11] = '{
        '{ 4, 14, 24,  5, 35,  6, 26, 17, 37, -1, -1},
        '{ 4, 34, 15, 25, 35, 16, 36,  7, 17, 27, 37},
        '{ 4, 24, 15, 35,  6, 26, 36, 17, 27, -1, -1},
        '{14, 34,  5, 15, 25, 35, 16, 26,  7, 17, 37}
    };

    function automatic logic [3:0] gfmul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] y;
        y = '0;
        for (int k = 0; k < 4; k++)
            for (int t = 0; t < 11; t++)
                if (TERMS[k][t] >= 0)
                    y[k] = y[k] ^ (a[TERMS[k][t] / 10] & b[(TERMS[k][t] % 10) - 4]);
        return y;
    endfunction

    function automatic int rr_winner(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++)
            if (v[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    typedef struct {
        logic [1:0] id;
        logic [3:0] ya;
        logic [3:0] yb;
        bit         in_s2;
    } item_t;

    item_t q[$];
    int    ptr = 0;

    logic [3:0] last_rdy;
    logic       last_v;
    logic [1:0] last_id;
    logic [3:0] last_y0, last_y1;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check at +1, update model at posedge.
    task automatic step(input logic [3:0] v, input logic rr);
        int     w;
        bit     acc;
        bit     s2adv;
        logic [3:0] er;
        item_t  it;
        req_valid = v;
        rsp_ready = rr;
        #1;
        acc = !(q.size() == 2 && !rr);
        w   = rr_winner(v, ptr);
        er  = (acc && w >= 0) ? (4'b0001 << w) : 4'b0000;
        chk("req_ready0", {12'h0, rdy0}, {12'h0, er});
        chk("req_ready1", {12'h0, rdy1}, {12'h0, er});
        chk("rsp_valid0", {15'h0, v0}, {15'h0, (q.size() > 0 && q[0].in_s2)});
        chk("rsp_valid1", {15'h0, v1}, {15'h0, (q.size() > 0 && q[0].in_s2)});
        chk("busy", {14'h0, busy0, busy1}, {14'h0, {2{q.size() != 0}}});
        if (q.size() > 0 && q[0].in_s2) begin
            chk("rsp_id0", {14'h0, id0}, {14'h0, q[0].id});
            chk("rsp_id1", {14'h0, id1}, {14'h0, q[0].id});
            chk("rsp_y0", {12'h0, y0}, {12'h0, q[0].ya});
            chk("rsp_y1", {12'h0, y1}, {12'h0, q[0].yb});
        end
        last_rdy = rdy0;
        last_v   = v0;
        last_id  = id0;
        last_y0  = y0;
        last_y1  = y1;
        @(posedge clk);
        s2adv = !(q.size() > 0 && q[0].in_s2) || rr;
        if (s2adv) begin
            if (q.size() > 0 && q[0].in_s2) void'(q.pop_front());
            foreach (q[i]) q[i].in_s2 = 1'b1;
        end
        if (acc && w >= 0) begin
            it.id    = 2'(w);
            it.ya    = gfmul(req_a[w*4 +: 4], req_b[w*4 +: 4]);
            it.yb    = it.ya ^ req_c[w*4 +: 4];
            it.in_s2 = 1'b0;
            q.push_back(it);
            ptr = (w + 1) % 4;
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, "_rsp_valid"}, {14'h0, v0, v1}, 16'h0);
        chk({tag, "_busy"}, {14'h0, busy0, busy1}, 16'h0);
        chk({tag, "_req_ready"}, {8'h0, rdy0, rdy1}, 16'h0);
        chk({tag, "_rsp_y_id"}, {4'h0, y0, y1, id0, id1}, 16'h0);
        q.delete();
        ptr = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] ystall;
        #2 rst_n = 1'b0;
        @(negedge clk);
        do_reset("rst0");

        // Single request on port 0: 1*1.
        req_a = 16'h0001; req_b = 16'h0001; req_c = 16'h000F;
        step(4'b0001, 1'b1);
        step(4'b0000, 1'b1);
        chk("r036_y", {12'h0, y0}, 16'h7);
        chk("r036_id", {14'h0, id0}, 16'h0);
        chk("r036_yc", {12'h0, y1}, 16'h8);
        step(4'b0000, 1'b1);
        chk("r036_idle", {15'h0, busy0}, 16'h0);

        // Port 2: 2*1, then zero operand.
        req_a = 16'h0200; req_b = 16'h0100; req_c = 16'h0F00;
        step(4'b0100, 1'b1);
        step(4'b0000, 1'b1);
        chk("r037_y", {12'h0, y0}, 16'h9);
        chk("r037_yc", {12'h0, y1}, 16'h6);
        chk("r037_id", {14'h0, id0}, 16'h2);
        req_a = 16'h0000; req_b = 16'($urandom);
        step(4'b0100, 1'b1);
        step(4'b0000, 1'b1);
        chk("r037_zero", {12'h0, y0}, 16'h0);
        chk("r037_zeroc", {12'h0, y1}, 16'hF);
        step(4'b0000, 1'b1);

        // All requesters held: grants rotate with no bubbles.
        do_reset("rst1");
        req_a = 16'h4321; req_b = 16'h8765; req_c = 16'hCBA9;
        for (int i = 0; i < 10; i++) begin
            step(4'b1111, 1'b1);
            chk("r038_grant", {12'h0, last_rdy}, 16'(4'b0001 << (i % 4)));
            if (i >= 2) chk("r038_id", {13'h0, last_v, last_id}, 16'({1'b1, 2'(i - 2)}));
        end
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);

        // Backpressure with two accepted requests.
        do_reset("rst2");
        req_a = 16'h0003; req_b = 16'h0005;
        step(4'b1111, 1'b0);
        step(4'b1111, 1'b0);
        ystall = gfmul(4'h3, 4'h5);
        for (int i = 0; i < 3; i++) begin
            step(4'b1111, 1'b0);
            chk("r039_stall_rdy", {12'h0, last_rdy}, 16'h0);
            chk("r039_stable_y", {12'h0, last_y0}, {12'h0, ystall});
        end
        step(4'b0000, 1'b1);
        chk("r039_drain0", {13'h0, last_v, last_id}, 16'h4);
        step(4'b0000, 1'b1);
        chk("r039_drain1", {13'h0, last_v, last_id}, 16'h5);
        step(4'b1111, 1'b1);
        chk("r039_resume", {12'h0, last_rdy}, 16'h4);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);

        // Reset with both stages full, then first grant from 0.
        req_a = 16'hA5C3; req_b = 16'h3C5A; req_c = 16'h1234;
        step(4'b1111, 1'b1);
        step(4'b1111, 1'b1);
        chk("r040_full", {15'h0, busy0}, 16'h1);
        do_reset("r040");
        step(4'b0110, 1'b1);
        chk("r040_grant", {12'h0, last_rdy}, 16'h2);
        for (int i = 0; i < 4; i++) step(4'b0000, 1'b1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            req_a = 16'($urandom);
            req_b = 16'($urandom);
            req_c = 16'($urandom);
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 4; i++) step(4'b0000, 1'b1);
        chk("final_empty", {15'h0, busy0}, 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gf16_mult_arbiter.md
GF16_MULT_ARBITER -- requirements
Module: gf16_mult_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, is the number of requesters; this revision supports only 4.
REQ-002 Parameter ADD_CONSTANT, default 0; when 1, the result is the product XOR c; when 0, c is ignored.
REQ-003 clk  input  1  single clock, rising-edge active.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  4  per-requester request valid.
REQ-006 req_a, req_b, req_c  input  16 each  packed 4x4-bit operands; requester i uses bits [4i+3:4i].
REQ-007 req_ready  output  4  per-requester accept; a request is accepted on an edge where req_valid[i]&req_ready[i].
REQ-008 rsp_valid  output  1  result valid.
REQ-009 rsp_ready  input  1  downstream accept; a result is consumed on an edge where rsp_valid&rsp_ready.
REQ-010 rsp_id  output  2  index of the requester owning rsp_y.
REQ-011 rsp_y  output  4  GF(16) result.
REQ-012 busy  output  1  high when either pipeline stage holds valid data.

Function
REQ-013 The block shall share one GF(16) multiplier among the requesters through two register stages: S1 (operands a,b,c,id) and S2 (rsp_y, rsp_id, rsp_valid).
REQ-014 The multiplier shall compute, with x0..x3=a[0..3] and x4..x7=b[0..3]: y0=x0x4^x1x4^x2x4^x0x5^x3x5^x0x6^x2x6^x1x7^x3x7.
REQ-015 y1=x0x4^x3x4^x1x5^x2x5^x3x5^x1x6^x3x6^x0x7^x1x7^x2x7^x3x7.
REQ-016 y2=x0x4^x2x4^x1x5^x3x5^x0x6^x2x6^x3x6^x1x7^x2x7.
REQ-017 y3=x1x4^x3x4^x0x5^x1x5^x2x5^x3x5^x1x6^x2x6^x0x7^x1x7^x3x7.
REQ-018 Stage S2 shall advance when S2 is empty or rsp_ready=1; S2 then loads the S1 product and id, and its valid flag takes S1's valid flag.
REQ-019 Stage S1 shall accept a new request when S1 is empty or S1 is advancing.
REQ-020 Exactly one of req_ready[i] shall be high in a cycle, namely for the round-robin winner among asserted req_valid, and only when S1 can accept; otherwise req_ready shall be 0.
REQ-021 req_ready may depend combinationally on req_valid and rsp_ready.
REQ-022 The round-robin pointer p shall give priority order p, p+1, ..., wrapping mod 4; after a grant to i, p becomes (i+1) mod 4.
REQ-023 The pointer shall be unchanged on any cycle without a grant.
REQ-024 Latency shall be 2: a request accepted at edge t appears on rsp_valid after edge t+1, provided S2 was not stalled.
REQ-025 Throughput shall be 1 result per cycle when rsp_ready=1.
REQ-026 When S2 is valid and rsp_ready=0, rsp_y and rsp_id shall remain stable.
REQ-027 When both stages are full under stall, all req_ready shall be 0 and no data shall be lost or reordered.
REQ-028 Results shall leave in acceptance order.
REQ-029 A requester with req_valid held high shall be granted within 4 grant opportunities.
REQ-030 A requester dropping req_valid before acceptance shall cause no side effect.

Reset
REQ-031 While rst_n=0, asynchronously: S1/S2 valid=0, rsp_valid=0, rsp_y=0, rsp_id=0, operand registers=0, p=0, busy=0, req_ready=0.
REQ-032 A reset asserted mid-operation shall discard all in-flight requests without producing a response.
REQ-033 The first grant after reset release shall follow priority order starting at requester 0.

Structure
REQ-034 A shared package shall hold N_REQ, the id width (2), the nibble width (4), and the packed-operand slice helper.
REQ-035 The multiplier shall be one instance of the team's Mult_GF16 sub-module with __ADD_CONSTANT=ADD_CONSTANT, placed between S1 and S2; no other sub-modules.

Verification
REQ-036 ADD_CONSTANT=0, single request on port 0 with a=0x1, b=0x1, rsp_ready=1 -> rsp_y=0x7 and rsp_id=0 two edges after accept; busy then returns 0.
REQ-037 Port 2 with a=0x2, b=0x1 -> 0x9; with ADD_CONSTANT=1 and c=0xF -> 0x6; a=0x0 with any b -> 0x0 (0xF with ADD_CONSTANT=1, c=0xF).
REQ-038 All 4 req_valid held after reset, rsp_ready=1 -> grants 0,1,2,3,0,... one per cycle; rsp_id follows 0,1,2,3 with no bubbles.
REQ-039 rsp_ready=0 with 2 requests accepted -> req_ready=0x0 and rsp_y stable; rsp_ready=1 -> both results drain in order, then granting resumes.
REQ-040 rst_n pulsed low with S1 and S2 full -> rsp_valid=0 immediately without waiting for clk; after release, first grant goes to the lowest-index valid requester starting from 0, and the flushed results never appear.
